// File: rtl/frame_scanout.sv
// frame_scanout: raster timing and 1-bpp scanout from the display bank, MSB first.
// Define SCANOUT_TEST_PATTERN_EN to add a checkerboard override input (test_pattern).
module frame_scanout #(
  parameter int DATA_WIDTH           = 16,
  parameter int BUFFER_ADDRESS_WIDTH = 13,
  parameter int H_ACTIVE             = 512,
  parameter int H_FP                 = 16,
  parameter int H_SYNC               = 64,
  parameter int H_BP                 = 48,
  parameter int V_ACTIVE             = 256,
  parameter int V_FP                 = 10,
  parameter int V_SYNC               = 2,
  parameter int V_BP                 = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           bufferData,
  input  logic                            swap_req,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic                            test_pattern,
`endif
  output logic [BUFFER_ADDRESS_WIDTH-1:0] bufferAddress,
  output logic                            buffer_select,
  output logic                            swap_ack,
  output logic                            hsync,
  output logic                            vsync,
  output logic                            active,
  output logic                            pixel,
  output logic                            frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WPL     = H_ACTIVE / 16;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int WW      = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int AW      = BUFFER_ADDRESS_WIDTH;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_PRE  = HW'(H_TOTAL - 2);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_FEND = HW'(H_ACTIVE - 16);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    IDLE,
    PENDING
  } swap_state_t;

  swap_state_t state_q;
  swap_state_t state_d;

  logic [HW-1:0]         h_cnt;
  logic [HW-1:0]         h_nxt;
  logic [VW-1:0]         v_cnt;
  logic [VW-1:0]         v_nxt;
  logic [VW-1:0]         next_line;
  logic [HW-1:0]         h_plus2;
  logic [VW-1:0]         fetch_line;
  logic [WW-1:0]         fetch_word;
  logic [AW-1:0]         fetch_addr;
  logic                  fetch;
  logic                  load;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic                  src_bit;
  logic                  act_nxt;
  logic                  pix_nxt;
  logic                  hs_nxt;
  logic                  vs_nxt;
  logic                  fs_nxt;
  logic                  at_vblank;
  logic                  swap_now;

  // Raster position of the next cycle; every output register is
  // computed from it so all outputs line up with h_cnt/v_cnt.
  always_comb begin
    h_nxt = h_cnt + HW'(1);
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end
  end

  always_comb begin
    act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hs_nxt  = !((h_nxt >= H_SS) && (h_nxt < H_SE));
    vs_nxt  = !((v_nxt >= V_SS) && (v_nxt < V_SE));
    fs_nxt  = (h_nxt == '0) && (v_nxt == '0);
  end

  // Word k is addressed two clocks before its first pixel; word 0
  // of a line is therefore fetched at the tail of the previous line.
  always_comb begin
    next_line  = (v_nxt == V_LAST) ? '0 : v_nxt + VW'(1);
    h_plus2    = h_nxt + HW'(2);
    fetch      = 1'b0;
    fetch_line = v_nxt;
    fetch_word = '0;
    if (h_nxt == H_PRE) begin
      fetch      = next_line < V_ACT;
      fetch_line = next_line;
    end else if ((h_nxt[3:0] == 4'hE) && (h_nxt < H_FEND) &&
                 (v_nxt < V_ACT)) begin
      fetch      = 1'b1;
      fetch_word = WW'(h_plus2 >> 4);
    end
    fetch_addr = AW'(int'(fetch_line) * WPL) + AW'(fetch_word);
  end

  always_comb begin
    load = (h_cnt == H_LAST) ||
           ((h_cnt[3:0] == 4'hF) && (h_cnt < H_ACT));
    if (load) begin
      shift_d = {bufferData[DATA_WIDTH-2:0], 1'b0};
      src_bit = bufferData[DATA_WIDTH-1];
    end else begin
      shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
      src_bit = shift_q[DATA_WIDTH-1];
    end
`ifdef SCANOUT_TEST_PATTERN_EN
    if (test_pattern) begin
      pix_nxt = act_nxt & (h_nxt[3] ^ v_nxt[3]);
    end else begin
      pix_nxt = act_nxt & src_bit;
    end
`else
    pix_nxt = act_nxt & src_bit;
`endif
  end

  // A request seen in the swap cycle itself is absorbed by that swap.
  always_comb begin
    at_vblank = (h_nxt == '0) && (v_nxt == V_ACT);
    state_d   = state_q;
    swap_now  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (swap_req) state_d = PENDING;
      end
      PENDING: begin
        if (at_vblank) begin
          swap_now = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      active      <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      active      <= act_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      frame_start <= fs_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q       <= '0;
      pixel         <= 1'b0;
      bufferAddress <= '0;
    end else begin
      shift_q <= shift_d;
      pixel   <= pix_nxt;
      if (fetch) bufferAddress <= fetch_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer_select <= 1'b0;
      swap_ack      <= 1'b0;
    end else begin
      swap_ack <= swap_now;
      if (swap_now) buffer_select <= ~buffer_select;
    end
  end

endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: directed bench for frame_scanout with a short vertical raster.
// Full horizontal timing, 8 active lines of 14, so a frame is 8960 clocks.
module tb_frame_scanout;

  localparam int HT = 640;
  localparam int VT = 14;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bufferData;
  logic        swap_req = 1'b0;
  logic [12:0] bufferAddress;
  logic        buffer_select;
  logic        swap_ack;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        pixel;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [0:16383];

  int   rh = 0;
  int   rv = 0;
  logic armed = 1'b0;
  logic fresh = 1'b1;
  logic exp_sel = 1'b0;
  logic sel_prev = 1'b0;
  int   cyc = 0;
  int   last_fs = -1;
  int   fs_period = 0;
  int   ack_cnt = 0;
  int   err_h = 0;
  int   err_v = 0;
  int   err_act = 0;
  int   err_pix = 0;
  int   err_fs = 0;
  int   err_sel = 0;
  int   a0 = 0;

  always #5 clk = ~clk;

  frame_scanout #(
    .V_ACTIVE(8),
    .V_FP    (2),
    .V_SYNC  (2),
    .V_BP    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bufferData   (bufferData),
    .swap_req     (swap_req),
    .bufferAddress(bufferAddress),
    .buffer_select(buffer_select),
    .swap_ack     (swap_ack),
    .hsync        (hsync),
    .vsync        (vsync),
    .active       (active),
    .pixel        (pixel),
    .frame_start  (frame_start)
  );

  function automatic logic [15:0] word_of(input logic b, input int a);
    logic [15:0] w;
    if (a == 0) w = 16'h8001;
    else if (a == 31) w = 16'hFFFF;
    else if (a < 32) w = 16'h0000;
    else w = 16'(a * 40503) ^ 16'h5A5A;
    return b ? ~w : w;
  endfunction

  function automatic logic exp_pixel(input int h, input int v);
    logic [15:0] w;
    if (h >= 512 || v >= 8) return 1'b0;
    if (fresh && v == 0 && h < 16) return 1'b0;
    w = word_of(exp_sel, v * 32 + h / 16);
    return w[15 - (h % 16)];
  endfunction

  initial begin
    for (int a = 0; a < 16384; a++) begin
      if (a < 256) mem[a] = word_of(1'b0, a);
      else if (a >= 8192 && a < 8448) mem[a] = word_of(1'b1, a - 8192);
      else mem[a] = 16'h0000;
    end
  end

  always @(posedge clk) bufferData <= mem[{buffer_select, bufferAddress}];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rh <= 0;
      rv <= 0;
    end else if (rh == HT - 1) begin
      rh <= 0;
      rv <= (rv == VT - 1) ? 0 : rv + 1;
    end else begin
      rh <= rh + 1;
    end
  end

  // Per-cycle raster monitor against the position model.
  always @(negedge clk) begin
    logic first, eh, ev, ea, ef, ep;
    if (rst || !armed) begin
      sel_prev = buffer_select;
      last_fs  = -1;
      fresh    = 1'b1;
    end else begin
      cyc++;
      first = fresh && rh == 0 && rv == 0;
      eh = !(rh >= 528 && rh < 592);
      ev = !(rv >= 10 && rv < 12);
      ea = !first && rh < 512 && rv < 8;
      ef = !first && rh == 0 && rv == 0;
      ep = exp_pixel(rh, rv);
      if (hsync !== eh) err_h++;
      if (vsync !== ev) err_v++;
      if (active !== ea) err_act++;
      if (frame_start !== ef) err_fs++;
      if (pixel !== ep) err_pix++;
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) fs_period = cyc - last_fs;
        last_fs = cyc;
      end
      if (swap_ack === 1'b1) ack_cnt++;
      if (buffer_select !== sel_prev && !(rh == 0 && rv == 8)) err_sel++;
      sel_prev = buffer_select;
      if (rv == 1) fresh = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rh == h && rv == v) && n < 2 * FRAME);
    check($sformatf("reach_%0d_%0d", h, v), (rh == h && rv == v), 1);
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_active"}, active, 0);
    check({tag, "_pixel"}, pixel, 0);
    check({tag, "_addr"}, bufferAddress, 0);
    check({tag, "_sel"}, buffer_select, 0);
    check({tag, "_ack"}, swap_ack, 0);
    check({tag, "_fs"}, frame_start, 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    armed = 1'b1;
    #1 check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // frame A: fetch address trace
    wait_pos(638, 0);
    check("addr_l0_638", bufferAddress, 32);
    wait_pos(494, 7);
    check("addr_last", bufferAddress, 255);
    wait_pos(0, 10);
    check("addr_hold_vbl", bufferAddress, 255);
    wait_pos(637, 13);
    check("addr_hold_pre", bufferAddress, 255);
    wait_pos(638, 13);
    check("addr_l0_prefetch", bufferAddress, 0);

    // frame B: line-0 pixels, hsync edges, swap request mid-frame
    wait_pos(0, 0);
    check("fs_b", frame_start, 1);
    check("px_0", pixel, 1);
    wait_pos(1, 0);
    check("px_1", pixel, 0);
    wait_pos(15, 0);
    check("px_15", pixel, 1);
    wait_pos(16, 0);
    check("px_16", pixel, 0);
    wait_pos(495, 0);
    check("px_495", pixel, 0);
    wait_pos(496, 0);
    check("px_496", pixel, 1);
    wait_pos(511, 0);
    check("px_511", pixel, 1);
    check("act_511", active, 1);
    wait_pos(512, 0);
    check("px_512", pixel, 0);
    check("act_512", active, 0);
    wait_pos(527, 1);
    check("hs_527", hsync, 1);
    wait_pos(528, 1);
    check("hs_528", hsync, 0);
    wait_pos(591, 1);
    check("hs_591", hsync, 0);
    wait_pos(592, 1);
    check("hs_592", hsync, 1);
    wait_pos(100, 5);
    pulse_swap();
    check("sel_after_req", buffer_select, 0);
    wait_pos(639, 7);
    check("sel_pre_vbl", buffer_select, 0);
    check("ack_pre_vbl", swap_ack, 0);
    wait_pos(0, 8);
    check("sel_swap1", buffer_select, 1);
    check("ack_swap1", swap_ack, 1);
    exp_sel = 1'b1;
    wait_pos(1, 8);
    check("ack_swap1_end", swap_ack, 0);
    wait_pos(0, 9);
    check("vs_9", vsync, 1);
    wait_pos(0, 10);
    check("vs_10", vsync, 0);
    wait_pos(639, 11);
    check("vs_11", vsync, 0);
    wait_pos(0, 12);
    check("vs_12", vsync, 1);

    // frame C: other bank shown; request merged into the swap cycle
    wait_pos(0, 0);
    check("px_b1_0", pixel, 0);
    wait_pos(1, 0);
    check("px_b1_1", pixel, 1);
    check("fs_period", fs_period, FRAME);
    wait_pos(10, 3);
    pulse_swap();
    wait_pos(639, 7);
    pulse_swap();
    check("sel_swap2", buffer_select, 0);
    check("ack_swap2", swap_ack, 1);
    exp_sel = 1'b0;
    wait_pos(0, 9);
    a0 = ack_cnt;

    // frame D: nothing pending after the merge
    wait_pos(0, 8);
    check("sel_no_swap", buffer_select, 0);
    check("ack_no_swap", swap_ack, 0);
    wait_pos(0, 9);
    check("ack_cnt_d", ack_cnt, a0);

    // frame E: three requests collapse into one swap
    wait_pos(10, 1);
    pulse_swap();
    wait_pos(10, 3);
    pulse_swap();
    wait_pos(10, 5);
    pulse_swap();
    wait_pos(0, 8);
    check("sel_swap3", buffer_select, 1);
    check("ack_swap3", swap_ack, 1);
    exp_sel = 1'b1;
    wait_pos(0, 9);
    check("ack_cnt_e", ack_cnt, a0 + 1);

    // frame F: reset mid-frame
    wait_pos(300, 5);
    check("act_pre_rst", active, 1);
    rst = 1'b1;
    exp_sel = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_pos(1, 0);
    check("post_rst_act", active, 1);
    check("post_rst_px1", pixel, 0);
    wait_pos(15, 0);
    check("post_rst_px15", pixel, 0);
    wait_pos(496, 0);
    check("post_rst_px496", pixel, 1);
    wait_pos(0, 1);

    check("hsync_trace", err_h, 0);
    check("vsync_trace", err_v, 0);
    check("active_trace", err_act, 0);
    check("pixel_trace", err_pix, 0);
    check("fs_trace", err_fs, 0);
    check("sel_trace", err_sel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
